stream_memory: RTL and testbench
================================

STREAM_MEMORY -- requirements
Module: stream_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of storage words (power of 2, >=2).
REQ-003 SHALL have localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-004 SHALL have one clock and one reset: the block is clocked by axis_aclk only; reset axis_areset is synchronous and active-high.
REQ-005 axis_aclk  in  1  sole clock, all state changes on its rising edge.
REQ-006 axis_areset  in  1  synchronous active-high reset.
REQ-007 s01_axis_tdata  in  DATA_WIDTH  write-packet data.
REQ-008 s01_axis_tstrb  in  DATA_WIDTH/8  per-byte write enable.
REQ-009 s01_axis_tvalid  in  1  write beat valid.
REQ-010 s01_axis_tlast  in  1  last beat of write packet.
REQ-011 s01_axis_tready  out  1  block accepts write beat.
REQ-012 m01_axis_tdata  out  DATA_WIDTH  read-packet data.
REQ-013 m01_axis_tstrb  out  DATA_WIDTH/8  read byte qualifier.
REQ-014 m01_axis_tvalid  out  1  read beat valid.
REQ-015 m01_axis_tlast  out  1  last beat of read packet.
REQ-016 m01_axis_tready  in  1  downstream accepts read beat.
REQ-017 rd_start  in  1  single-cycle request to stream stored packet out.
REQ-018 word_count  out  ADDR_WIDTH+1  words currently stored.
REQ-019 overflow  out  1  sticky flag: write packet truncated at DEPTH.

Function
REQ-020 SHALL implement FSM states S_IDLE, S_WRITE, S_HOLD, S_READ.
REQ-021 Beat accepted on s01 SHALL mean s01_axis_tvalid && s01_axis_tready at a rising edge; m01 likewise with m01 signals.
REQ-022 s01_axis_tready SHALL be combinational: 1 in S_IDLE and S_WRITE, 0 in S_HOLD and S_READ.
REQ-023 Accepted write beat SHALL store into mem[word_count], updating only bytes whose tstrb bit is 1; other bytes keep old content; word_count increments by 1.
REQ-024 S_IDLE: accepted beat with tlast=1 -> S_HOLD; with tlast=0 -> S_WRITE.
REQ-025 S_WRITE: accepted beat with tlast=1 -> S_HOLD; accepted beat filling index DEPTH-1 with tlast=0 -> S_HOLD and overflow<=1 (packet truncated, later beats stall).
REQ-026 S_HOLD: rd_start=1 -> S_READ; rd_start SHALL be ignored in all other states.
REQ-027 On the edge sampling rd_start in S_HOLD: m01_axis_tvalid<=1, m01_axis_tdata<=mem[0], m01_axis_tlast<=(word_count==1), m01_axis_tstrb<=all ones (first beat one cycle after rd_start).
REQ-028 S_READ: m01 outputs SHALL hold stable while tvalid && !tready; on each accepted beat the next word SHALL be loaded the same edge (1 beat/cycle throughput), tlast high only on index word_count-1.
REQ-029 Accepted beat with tlast=1 SHALL drive tvalid<=0, tlast<=0, word_count<=0, next state S_IDLE.
REQ-030 word_count SHALL never exceed DEPTH and SHALL not change in S_HOLD or S_READ.
REQ-031 overflow SHALL remain 1 until reset.

Reset
REQ-032 axis_areset=1 at an edge SHALL force S_IDLE, word_count=0, overflow=0, m01_axis_tvalid=0, m01_axis_tlast=0, m01_axis_tdata=0, m01_axis_tstrb=0, regardless of state (including mid-read).
REQ-033 Memory contents SHALL NOT be reset.

Structure
REQ-034 Package stream_memory_pkg SHALL hold the FSM state enum typedef.
REQ-035 Storage SHALL be sub-module stream_memory_ram: synchronous byte-enable write, combinational read, parameterized DATA_WIDTH/DEPTH.

Verification
REQ-036 Write 3 beats 0x11111111/0x22222222/0x33333333 (tlast on 3rd), rd_start, tready=1 -> same 3 words out on 3 consecutive cycles, tlast on 3rd, word_count 3 then 0.
REQ-037 Write 0xAABBCCDD then 0x00000099 tstrb=0001 to same slot after reset -> read returns 0xAABBCC99.
REQ-038 Write 20 beats without tlast, DEPTH=16 -> tready drops after 16th, overflow=1, read yields 16 words, tlast on 16th.
REQ-039 During read toggle m01_axis_tready 1,0,0,1 -> tdata/tlast held during stall, no word lost or duplicated.
REQ-040 rd_start in S_IDLE/S_WRITE -> no m01 tvalid; assert axis_areset mid-read -> tvalid=0, word_count=0, overflow=0 next cycle.

Source files
------------

// File: rtl/stream_memory_pkg.sv
// Shared types for the stream_memory packet buffer.
// Holds the controller state encoding used by the top level.
package stream_memory_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2,
        S_READ  = 2'd3
    } state_t;

endpackage

// File: rtl/stream_memory_ram.sv
// Word storage for stream_memory: synchronous byte-enable write port,
// combinational read port. Contents are never cleared.
module stream_memory_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_memory.sv
// Single-packet store-and-forward buffer: captures one AXI-Stream packet on
// s01, holds it, then replays it on m01 when rd_start is pulsed.
module stream_memory
    import stream_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
    input  logic [STRB_WIDTH-1:0] s01_axis_tstrb,
    input  logic                  s01_axis_tvalid,
    input  logic                  s01_axis_tlast,
    output logic                  s01_axis_tready,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic [STRB_WIDTH-1:0] m01_axis_tstrb,
    output logic                  m01_axis_tvalid,
    output logic                  m01_axis_tlast,
    input  logic                  m01_axis_tready,
    input  logic                  rd_start,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

    state_t                state;
    state_t                next_state;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_launch;
    logic                  wr_full;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_fire   = s01_axis_tvalid && s01_axis_tready;
    assign rd_fire   = (state == S_READ) && m01_axis_tvalid && m01_axis_tready;
    assign rd_launch = (state == S_HOLD) && rd_start;
    assign wr_full   = (word_count == LAST_IDX);

    // rd_ptr always names the next word to present; word 0 is fetched on launch.
    assign rd_addr = (state == S_HOLD) ? '0 : rd_ptr[ADDR_WIDTH-1:0];

    stream_memory_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (axis_aclk),
        .we   (wr_fire),
        .waddr(word_count[ADDR_WIDTH-1:0]),
        .wdata(s01_axis_tdata),
        .wstrb(s01_axis_tstrb),
        .raddr(rd_addr),
        .rdata(rd_word)
    );

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (wr_fire) begin
                    next_state = s01_axis_tlast ? S_HOLD : S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_fire && (s01_axis_tlast || wr_full)) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rd_start) begin
                    next_state = S_READ;
                end
            end
            S_READ: begin
                if (rd_fire && m01_axis_tlast) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        s01_axis_tready = (state == S_IDLE) || (state == S_WRITE);
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            word_count      <= '0;
            overflow        <= 1'b0;
            rd_ptr          <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
        end else begin
            if (wr_fire) begin
                word_count <= word_count + ONE;
                // Packet ran past the last slot without tlast: truncate it.
                if ((state == S_WRITE) && wr_full && !s01_axis_tlast) begin
                    overflow <= 1'b1;
                end
            end
            if (rd_launch) begin
                m01_axis_tvalid <= 1'b1;
                m01_axis_tdata  <= rd_word;
                m01_axis_tlast  <= (word_count == ONE);
                m01_axis_tstrb  <= '1;
                rd_ptr          <= ONE;
            end else if (rd_fire) begin
                if (m01_axis_tlast) begin
                    m01_axis_tvalid <= 1'b0;
                    m01_axis_tlast  <= 1'b0;
                    word_count      <= '0;
                end else begin
                    m01_axis_tdata <= rd_word;
                    m01_axis_tlast <= (rd_ptr == (word_count - ONE));
                    rd_ptr         <= rd_ptr + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_memory.sv
// Directed self-checking bench for stream_memory (DATA_WIDTH=32, DEPTH=16).
// Each task drives one scenario and compares against hand-computed values.
module tb_stream_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        rd_start;
    logic [4:0]  word_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_memory #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .axis_aclk      (clk),
        .axis_areset    (rst),
        .s01_axis_tdata (s_tdata),
        .s01_axis_tstrb (s_tstrb),
        .s01_axis_tvalid(s_tvalid),
        .s01_axis_tlast (s_tlast),
        .s01_axis_tready(s_tready),
        .m01_axis_tdata (m_tdata),
        .m01_axis_tstrb (m_tstrb),
        .m01_axis_tvalid(m_tvalid),
        .m01_axis_tlast (m_tlast),
        .m01_axis_tready(m_tready),
        .rd_start       (rd_start),
        .word_count     (word_count),
        .overflow       (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_beat(input logic [31:0] d, input logic [3:0] st, input logic last);
        s_tdata  = d;
        s_tstrb  = st;
        s_tlast  = last;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_tvalid, m_tlast, m_tdata, m_tstrb} !== 38'd0) begin
            errors++;
            $display("FAIL reset_m01: got v=%0b l=%0b d=%h s=%h want all 0", m_tvalid, m_tlast, m_tdata, m_tstrb);
        end
        checks++;
        if (word_count !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got wc=%0d ovf=%0b want 0 0", word_count, overflow);
        end
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %0b want 1", s_tready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h11111111;
        exp_d[1] = 32'h22222222;
        exp_d[2] = 32'h33333333;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) write_beat(exp_d[i], 4'hF, i == 2);
        checks++;
        if (word_count !== 5'd3 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got wc=%0d rdy=%0b want 3 0", word_count, s_tready);
        end
        pulse_rd_start();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_d[i] || m_tlast !== (i == 2) || m_tstrb !== 4'hF) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%0b d=%h l=%0b s=%h want 1 %h %0b F",
                         i, m_tvalid, m_tdata, m_tlast, m_tstrb, exp_d[i], (i == 2));
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0 || word_count !== 5'd0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: got v=%0b wc=%0d rdy=%0b want 0 0 1", m_tvalid, word_count, s_tready);
        end
    endtask

    task automatic test_strobe();
        do_reset();
        write_beat(32'hAABBCCDD, 4'hF, 1'b1);
        do_reset();
        write_beat(32'h00000099, 4'h1, 1'b1);
        m_tready = 1'b1;
        pulse_rd_start();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'hAABBCC99 || m_tlast !== 1'b1) begin
            errors++;
            $display("FAIL strobe_merge: got v=%0b d=%h l=%0b want 1 aabbcc99 1", m_tvalid, m_tdata, m_tlast);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || word_count !== 5'd0) begin
            errors++;
            $display("FAIL strobe_done: got v=%0b wc=%0d want 0 0", m_tvalid, word_count);
        end
    endtask

    task automatic test_overflow();
        int accepted;
        int n;
        int last_at;
        int lasts;
        logic rdy;
        do_reset();
        accepted = 0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tstrb  = 4'hF;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 32'(accepted + 1);
            rdy = s_tready;
            tick();
            if (rdy) accepted++;
        end
        s_tvalid = 1'b0;
        checks++;
        if (accepted != 16 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_accept: got beats=%0d rdy=%0b want 16 0", accepted, s_tready);
        end
        checks++;
        if (overflow !== 1'b1 || word_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_flag: got ovf=%0b wc=%0d want 1 16", overflow, word_count);
        end
        m_tready = 1'b1;
        pulse_rd_start();
        n = 0;
        last_at = -1;
        lasts = 0;
        for (int c = 0; c < 24 && last_at < 0; c++) begin
            if (m_tvalid) begin
                checks++;
                if (m_tdata !== 32'(n + 1)) begin
                    errors++;
                    $display("FAIL ovf_data%0d: got %h want %h", n, m_tdata, 32'(n + 1));
                end
                if (m_tlast) begin
                    last_at = n;
                    lasts++;
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 16 || last_at != 15 || lasts != 1) begin
            errors++;
            $display("FAIL ovf_read: got beats=%0d last_idx=%0d want 16 15", n, last_at);
        end
        checks++;
        if (overflow !== 1'b1 || word_count !== 5'd0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%0b wc=%0d v=%0b want 1 0 0", overflow, word_count, m_tvalid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4];
        logic        pat [6];
        int          idx;
        exp_d[0] = 32'hA0A0A0A0;
        exp_d[1] = 32'hA1A1A1A1;
        exp_d[2] = 32'hA2A2A2A2;
        exp_d[3] = 32'hA3A3A3A3;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) write_beat(exp_d[i], 4'hF, i == 3);
        m_tready = 1'b1;
        pulse_rd_start();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            m_tready = pat[c];
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_d[idx] || m_tlast !== (idx == 3)) begin
                errors++;
                $display("FAIL bp_cycle%0d: got v=%0b d=%h l=%0b want 1 %h %0b",
                         c, m_tvalid, m_tdata, m_tlast, exp_d[idx], (idx == 3));
            end
            tick();
            if (pat[c]) idx++;
        end
        m_tready = 1'b1;
        checks++;
        if (m_tvalid !== 1'b0 || word_count !== 5'd0) begin
            errors++;
            $display("FAIL bp_done: got v=%0b wc=%0d want 0 0", m_tvalid, word_count);
        end
    endtask

    task automatic test_ignore_and_reset();
        do_reset();
        m_tready = 1'b1;
        pulse_rd_start();
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL ign_idle: got v=%0b rdy=%0b want 0 1", m_tvalid, s_tready);
        end
        write_beat(32'h5A5A5A5A, 4'hF, 1'b0);
        pulse_rd_start();
        checks++;
        if (m_tvalid !== 1'b0 || word_count !== 5'd1 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL ign_write: got v=%0b wc=%0d rdy=%0b want 0 1 1", m_tvalid, word_count, s_tready);
        end
        for (int i = 1; i < 16; i++) write_beat(32'(i), 4'hF, 1'b0);
        checks++;
        if (overflow !== 1'b1 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL rst_prep: got ovf=%0b rdy=%0b want 1 0", overflow, s_tready);
        end
        pulse_rd_start();
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00000001) begin
            errors++;
            $display("FAIL rst_midread: got v=%0b d=%h want 1 00000001", m_tvalid, m_tdata);
        end
        do_reset();
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'd0 || word_count !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got v=%0b l=%0b d=%h wc=%0d ovf=%0b want 0 0 0 0 0",
                     m_tvalid, m_tlast, m_tdata, word_count, overflow);
        end
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle: got rdy=%0b want 1", s_tready);
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        rd_start = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_strobe();
        test_overflow();
        test_backpressure();
        test_ignore_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
